// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state codes and constants for the instruction-fetch stage
package fetch_pkg;
  typedef logic [1:0] fetchState_t;
  localparam fetchState_t IDLE  = 2'd0;
  localparam fetchState_t FETCH = 2'd1;
  localparam fetchState_t HOLD  = 2'd2;
  localparam fetchState_t DROP  = 2'd3;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: request/acknowledge instruction-memory port (master = fetch stage, slave = memory)
interface fetch_stage_if #(parameter int INST_W = 32);
  logic req;
  logic [31:0] addr;
  logic ack;
  logic [INST_W-1:0] data;
  modport master(output req, addr, input ack, data);
  modport slave(input req, addr, output ack, data);
endinterface

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: saturating fetch/bubble counters, present only when FETCH_PERF_CNT_EN is defined
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        incFetch,
  input  logic        incBubble,
  output logic [31:0] Perf_Fetch_o,
  output logic [31:0] Perf_Bubble_o
);
  // count each event, sticking at all-ones instead of wrapping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      Perf_Fetch_o <= '0;
      Perf_Bubble_o <= '0;
    end else begin
      if (incFetch && !(&Perf_Fetch_o)) Perf_Fetch_o <= Perf_Fetch_o + 32'd1;
      if (incBubble && !(&Perf_Bubble_o)) Perf_Bubble_o <= Perf_Bubble_o + 32'd1;
    end
  end
endmodule
`endif

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem request/ack port and IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int INST_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              PC_Stall_i,
  input  logic              IF_ID_Stall_i,
  input  logic              Flush_i,
  input  logic [31:0]       Branch_Target_i,
  fetch_stage_if.master     imem,
  output logic [INST_W-1:0] IF_ID_Inst_o,
  output logic [31:0]       IF_ID_PC_o,
  output logic              IF_ID_Valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       Perf_Fetch_o,
  output logic [31:0]       Perf_Bubble_o
`endif
);
  fetchState_t state, stateD;
  logic [31:0] pcQ, pcD, dropAddrQ, dropAddrD, ifIdPcD;
  logic [INST_W-1:0] holdBuf, holdBufD, ifIdInstD;
  logic ifIdWr, ifIdValidD, stall, ack;

  assign stall = PC_Stall_i | IF_ID_Stall_i;
  assign imem.req = (state == FETCH) || (state == DROP);
  assign imem.addr = (state == DROP) ? dropAddrQ : pcQ;
  assign ack = imem.ack & imem.req;

  // next-state and IF/ID write decision; flush beats stall beats advance
  always_comb begin
    stateD = state;
    pcD = pcQ;
    dropAddrD = dropAddrQ;
    holdBufD = holdBuf;
    ifIdWr = 1'b0;
    ifIdValidD = 1'b0;
    ifIdInstD = INST_W'(NOP_INST);
    ifIdPcD = IF_ID_PC_o;
    case (state)
      IDLE: stateD = start_i ? FETCH : IDLE;
      FETCH: begin
        if (Flush_i) begin
          pcD = Branch_Target_i;
          dropAddrD = pcQ;
          ifIdWr = 1'b1;
          stateD = ack ? FETCH : DROP;
        end else if (ack && !stall) begin
          ifIdWr = 1'b1;
          ifIdValidD = 1'b1;
          ifIdInstD = imem.data;
          ifIdPcD = pcQ;
          pcD = pcQ + PC_INC;
        end else if (ack) begin
          holdBufD = imem.data;
          stateD = HOLD;
        end else begin
          ifIdWr = !stall;
        end
      end
      HOLD: begin
        if (Flush_i) begin
          pcD = Branch_Target_i;
          holdBufD = INST_W'(NOP_INST);
          ifIdWr = 1'b1;
          stateD = FETCH;
        end else if (!stall) begin
          ifIdWr = 1'b1;
          ifIdValidD = 1'b1;
          ifIdInstD = holdBuf;
          ifIdPcD = pcQ;
          pcD = pcQ + PC_INC;
          stateD = FETCH;
        end
      end
      default: begin
        pcD = Flush_i ? Branch_Target_i : pcQ;
        stateD = ack ? FETCH : DROP;
        ifIdWr = Flush_i | !stall;
      end
    endcase
  end

  // register FSM, PC, buffers and the IF/ID pipeline register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      pcQ <= RESET_PC;
      dropAddrQ <= RESET_PC;
      holdBuf <= INST_W'(NOP_INST);
      IF_ID_Inst_o <= INST_W'(NOP_INST);
      IF_ID_PC_o <= '0;
      IF_ID_Valid_o <= 1'b0;
    end else begin
      state <= stateD;
      pcQ <= pcD;
      dropAddrQ <= dropAddrD;
      holdBuf <= holdBufD;
      if (ifIdWr) begin
        IF_ID_Inst_o <= ifIdInstD;
        IF_ID_PC_o <= ifIdPcD;
        IF_ID_Valid_o <= ifIdValidD;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt uPerf (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .incFetch(ifIdWr & ifIdValidD),
    .incBubble(ifIdWr & !ifIdValidD),
    .Perf_Fetch_o(Perf_Fetch_o),
    .Perf_Bubble_o(Perf_Bubble_o)
  );
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + randomized bench for fetch_stage with a memory model and an IF/ID stream model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pcStall = 1'b0;
  logic ifIdStall = 1'b0;
  logic flush = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] inst, ifPc;
  logic valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfFetch, perfBubble;
`endif

  fetch_stage_if #(.INST_W(32)) imem ();

  fetch_stage dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .PC_Stall_i(pcStall),
    .IF_ID_Stall_i(ifIdStall),
    .Flush_i(flush),
    .Branch_Target_i(target),
    .imem(imem),
    .IF_ID_Inst_o(inst),
    .IF_ID_PC_o(ifPc),
    .IF_ID_Valid_o(valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Perf_Fetch_o(perfFetch),
    .Perf_Bubble_o(perfBubble)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int waitCnt = 0;
  logic [31:0] key = '0;

  // memory contents are a simple function of the address
  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ key;
  endfunction

  // memory: acknowledges a pending request once it has waited lat cycles
  always @(posedge clk) begin
    #1;
    if (rst) begin
      waitCnt = 0;
      imem.ack = 1'b0;
      imem.data = '0;
    end else if (imem.req && waitCnt >= lat) begin
      imem.ack = 1'b1;
      imem.data = memData(imem.addr);
      waitCnt = 0;
    end else begin
      imem.ack = 1'b0;
      imem.data = '0;
      waitCnt = imem.req ? waitCnt + 1 : 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model of the IF/ID stream: the next PC that must be delivered
  logic [31:0] expNext = '0;
  int delivered = 0;
  int expFetch = 0;
  int expBubble = 0;
  bit started = 1'b0;

  task automatic doReset();
    rst = 1'b1;
    start = 1'b0;
    pcStall = 1'b0;
    ifIdStall = 1'b0;
    flush = 1'b0;
    lat = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    expNext = 32'h0;
    delivered = 0;
    expFetch = 0;
    expBubble = 0;
    started = 1'b0;
  endtask

  // advance one clock and check the result against the stream model
  task automatic cycle();
    bit pStall, pFlush, pWait, pStart;
    logic [31:0] pAddr, pT, pInst, pPc;
    logic pValid;
    pStall = pcStall | ifIdStall;
    pFlush = flush;
    pStart = start;
    pT = target;
    pWait = imem.req && !imem.ack;
    pAddr = imem.addr;
    pInst = inst;
    pPc = ifPc;
    pValid = valid;
    @(posedge clk);
    #2;
    if (pWait) begin
      chk("addr_hold_req", 32'(imem.req), 32'd1);
      chk("addr_hold", imem.addr, pAddr);
    end
    if (started && pFlush) begin
      chk("flush_valid", 32'(valid), 32'd0);
      chk("flush_inst", inst, 32'h0);
      expNext = pT;
      expBubble++;
    end else if (pStall) begin
      chk("stall_valid", 32'(valid), 32'(pValid));
      chk("stall_inst", inst, pInst);
      chk("stall_pc", ifPc, pPc);
    end else if (valid) begin
      chk("seq_pc", ifPc, expNext);
      chk("seq_inst", inst, memData(expNext));
      expNext = expNext + 32'd4;
      delivered++;
      expFetch++;
    end else begin
      chk("bubble_inst", inst, 32'h0);
      if (started) expBubble++;
    end
    if (pStart) started = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lastV, nv;
    bit got, done;
    // reset values
    doReset();
    chk("rst_req", 32'(imem.req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", ifPc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", perfFetch, 32'h0);
    chk("rst_perf_bubble", perfBubble, 32'h0);
`endif
    // zero-wait memory: one instruction per cycle, first two edges after start
    start = 1'b1;
    cycle();
    chk("zw_first_req", 32'(imem.req), 32'd1);
    chk("zw_first_addr", imem.addr, 32'h0);
    chk("zw_first_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("zw_valid", 32'(valid), 32'd1);
      chk("zw_pc", ifPc, 32'(i * 4));
      chk("zw_inst", inst, 32'(i * 4));
    end
    // 3-cycle ack latency: two bubbles between instructions
    lat = 2;
    lastV = 0;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (valid) begin
        if (nv >= 2) chk("lat3_gap", 32'(i - lastV), 32'd3);
        lastV = i;
        nv++;
      end
    end
    chk("lat3_seen", 32'(nv >= 4), 32'd1);
    // two-cycle stall while PC 8 is acknowledged
    doReset();
    start = 1'b1;
    repeat (3) cycle();
    chk("st_addr8", imem.addr, 32'h8);
    pcStall = 1'b1;
    ifIdStall = 1'b1;
    cycle();
    chk("st_hold1", ifPc, 32'h4);
    cycle();
    chk("st_hold2", ifPc, 32'h4);
    chk("st_hold2_valid", 32'(valid), 32'd1);
    pcStall = 1'b0;
    ifIdStall = 1'b0;
    cycle();
    chk("st_rel_pc8", ifPc, 32'h8);
    cycle();
    chk("st_rel_pc12", ifPc, 32'hC);
    // flush while a request to 0x20 waits for its ack
    doReset();
    start = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = imem.req && imem.addr == 32'h1C;
    end
    chk("fl_reach_1c", 32'(done), 32'd1);
    lat = 3;
    cycle();
    chk("fl_addr20", imem.addr, 32'h20);
    flush = 1'b1;
    target = 32'h100;
    cycle();
    flush = 1'b0;
    chk("fl_drop_req", 32'(imem.req), 32'd1);
    chk("fl_drop_addr", imem.addr, 32'h20);
    chk("fl_drop_valid", 32'(valid), 32'd0);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      got = imem.ack;
      if (got) lat = 0;
      cycle();
      chk("fl_wait_valid", 32'(valid), 32'd0);
      if (got) done = 1'b1;
      else chk("fl_wait_addr", imem.addr, 32'h20);
    end
    chk("fl_ack_seen", 32'(done), 32'd1);
    chk("fl_new_addr", imem.addr, 32'h100);
    cycle();
    chk("fl_tgt_valid", 32'(valid), 32'd1);
    chk("fl_tgt_pc", ifPc, 32'h100);
    // flush together with IF/ID stall while holding a fetched instruction
    doReset();
    start = 1'b1;
    repeat (3) cycle();
    ifIdStall = 1'b1;
    cycle();
    chk("hf_hold_req", 32'(imem.req), 32'd0);
    flush = 1'b1;
    target = 32'h200;
    cycle();
    chk("hf_valid", 32'(valid), 32'd0);
    chk("hf_addr", imem.addr, 32'h200);
    flush = 1'b0;
    ifIdStall = 1'b0;
    cycle();
    chk("hf_tgt_pc", ifPc, 32'h200);
    chk("hf_tgt_inst", inst, memData(32'h200));
    // asynchronous reset in the middle of DROP
    doReset();
    start = 1'b1;
    repeat (2) cycle();
    lat = 5;
    cycle();
    flush = 1'b1;
    target = 32'h300;
    cycle();
    flush = 1'b0;
    cycle();
    chk("rd_pre_req", 32'(imem.req), 32'd1);
    chk("rd_pre_addr", imem.addr, 32'h8);
    #3;
    rst = 1'b1;
    #1;
    chk("rd_req", 32'(imem.req), 32'd0);
    chk("rd_valid", 32'(valid), 32'd0);
    chk("rd_addr", imem.addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rd_perf_fetch", perfFetch, 32'h0);
    chk("rd_perf_bubble", perfBubble, 32'h0);
`endif
    // randomized stalls, flushes and memory latency
    doReset();
    key = $urandom;
    start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      pcStall = ($urandom % 5) == 0;
      ifIdStall = ($urandom % 5) == 0;
      flush = i > 2 && ($urandom % 16) == 0;
      target = (($urandom % 4) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      lat = int'($urandom % 4);
      cycle();
    end
    chk("rnd_progress", 32'(delivered >= 40), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_perf_fetch", perfFetch, 32'(expFetch));
    chk("rnd_perf_bubble", perfBubble, 32'(expBubble));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
